// File: rtl/adpll_loop_filter.sv
// PI loop filter and lock detector for the ADPLL. It integrates PFD up/down pulses over
// fixed reference-clock windows and produces a saturated DCO frequency-select code.
module adpll_loop_filter #(
  parameter int CTRL_WIDTH = 5,
  parameter int WIN_LOG2   = 4,
  parameter int FRAC_BITS  = 4,
  parameter int KP_SHIFT   = 1,
  parameter int KI_SHIFT   = 3,
  parameter int INIT_CODE  = 16,
  parameter int LOCK_TOL   = 1,
  parameter int LOCK_COUNT = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         enable_i,
  input  logic                         up_i,
  input  logic                         down_i,
  output logic [CTRL_WIDTH-1:0]        freq_sel_o,
  output logic                         dco_enable_o,
  output logic                         code_valid_o,
  output logic                         locked_o,
  output logic signed [WIN_LOG2+1:0]   win_err_o
);

  localparam int IW  = CTRL_WIDTH + FRAC_BITS;
  localparam int EW  = WIN_LOG2 + 2;
  localparam int SW  = IW + EW + FRAC_BITS + 1;
  localparam int LCW = $clog2(LOCK_COUNT + 1);

  localparam logic [IW-1:0]         INIT_INTEG = IW'(INIT_CODE << FRAC_BITS);
  localparam logic signed [SW-1:0]  INTEG_MAX  = SW'((2**CTRL_WIDTH << FRAC_BITS) - 1);
  localparam logic signed [SW-1:0]  CODE_MAX   = SW'(2**CTRL_WIDTH - 1);
  localparam logic signed [EW-1:0]  TOL_P      = EW'(LOCK_TOL);
  localparam logic signed [EW-1:0]  TOL_N      = EW'(-LOCK_TOL);
  localparam logic [LCW-1:0]        LOCK_FULL  = LCW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_e;

  state_e                   state_q, state_d;
  logic [WIN_LOG2-1:0]      win_cnt_q, win_cnt_d;
  logic signed [EW-1:0]     acc_q, acc_d;
  logic [LCW-1:0]           lock_cnt_q, lock_cnt_d;
  logic [IW-1:0]            integ_q, integ_d;
  logic [CTRL_WIDTH-1:0]    freq_sel_q, freq_sel_d;
  logic                     dco_enable_q, dco_enable_d;
  logic                     code_valid_q, code_valid_d;
  logic                     locked_q, locked_d;
  logic signed [EW-1:0]     win_err_q, win_err_d;

  logic signed [EW-1:0]     step;
  logic signed [EW-1:0]     err;
  logic                     win_end;
  logic                     in_lock;
  logic signed [SW-1:0]     err_w;
  logic signed [SW-1:0]     integ_sum;
  logic signed [SW-1:0]     integ_new;
  logic signed [SW-1:0]     code_sum;
  logic signed [SW-1:0]     code_new;

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    if (up_i && !down_i)      step = EW'(1);
    else if (down_i && !up_i) step = '1;
    else                      step = '0;

    err     = acc_q + step;
    win_end = (win_cnt_q == '1);
    in_lock = (err >= TOL_N) && (err <= TOL_P);

    // Sums are formed at SW bits so nothing wraps before the clamp.
    err_w     = SW'(err);
    integ_sum = $signed(SW'(integ_q)) + ((err_w <<< FRAC_BITS) >>> KI_SHIFT);
    if (integ_sum[SW-1])             integ_new = '0;
    else if (integ_sum > INTEG_MAX)  integ_new = INTEG_MAX;
    else                             integ_new = integ_sum;

    code_sum = (integ_new >>> FRAC_BITS) + (err_w >>> KP_SHIFT);
    if (code_sum[SW-1])             code_new = '0;
    else if (code_sum > CODE_MAX)   code_new = CODE_MAX;
    else                            code_new = code_sum;

    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    acc_d        = acc_q;
    lock_cnt_d   = lock_cnt_q;
    integ_d      = integ_q;
    freq_sel_d   = freq_sel_q;
    code_valid_d = 1'b0;
    win_err_d    = win_err_q;

    if (!enable_i) begin
      // Disable clears like reset but keeps the last window error visible.
      state_d    = IDLE;
      win_cnt_d  = '0;
      acc_d      = '0;
      lock_cnt_d = '0;
      integ_d    = INIT_INTEG;
      freq_sel_d = CTRL_WIDTH'(INIT_CODE);
    end else begin
      case (state_q)
        IDLE: state_d = ACQUIRE;
        ACQUIRE, TRACK: begin
          win_cnt_d = win_cnt_q + 1'b1;
          acc_d     = err;
          if (win_end) begin
            acc_d        = '0;
            integ_d      = integ_new[IW-1:0];
            freq_sel_d   = code_new[CTRL_WIDTH-1:0];
            code_valid_d = 1'b1;
            win_err_d    = err;
            if (!in_lock) begin
              lock_cnt_d = '0;
              state_d    = ACQUIRE;
            end else begin
              lock_cnt_d = (lock_cnt_q == LOCK_FULL) ? lock_cnt_q : lock_cnt_q + 1'b1;
              if (lock_cnt_d == LOCK_FULL) state_d = TRACK;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    dco_enable_d = (state_d != IDLE);
    locked_d     = (state_d == TRACK);
  end

  // NOTE: state flops use non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      acc_q        <= '0;
      lock_cnt_q   <= '0;
      integ_q      <= INIT_INTEG;
      freq_sel_q   <= CTRL_WIDTH'(INIT_CODE);
      dco_enable_q <= 1'b0;
      code_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      win_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      acc_q        <= acc_d;
      lock_cnt_q   <= lock_cnt_d;
      integ_q      <= integ_d;
      freq_sel_q   <= freq_sel_d;
      dco_enable_q <= dco_enable_d;
      code_valid_q <= code_valid_d;
      locked_q     <= locked_d;
      win_err_q    <= win_err_d;
    end
  end

  assign freq_sel_o   = freq_sel_q;
  assign dco_enable_o = dco_enable_q;
  assign code_valid_o = code_valid_q;
  assign locked_o     = locked_q;
  assign win_err_o    = win_err_q;

endmodule
